// File: rtl/apb_timer_pkg.sv
// rtl/apb_timer_pkg.sv - register map, CTRL bit positions and counter states for the APB timer
package apb_timer_pkg;

  localparam logic [7:0] CTRL_OFF     = 8'h00;
  localparam logic [7:0] LOAD_OFF     = 8'h04;
  localparam logic [7:0] COUNT_OFF    = 8'h08;
  localparam logic [7:0] STATUS_OFF   = 8'h0C;
  localparam logic [7:0] PRESCALE_OFF = 8'h10;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_AR_BIT  = 1;
  localparam int CTRL_IRQ_BIT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - 8-bit prescaler emitting a one-cycle tick every div+1 cycles
module timer_prescaler (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] cnt_q, cnt_d;

  // >= rather than == so a div lowered below the running count ticks at once instead of wrapping
  assign tick = (cnt_q >= div);

  // Count up, restart on every tick or when the timer is (re)started
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clr || tick) cnt_d = 8'd0;
  end

  // Prescale counter register
  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/apb_timer_slave.sv
// rtl/apb_timer_slave.sv - APB timer slave; prescaler present only with TIMER_PRESCALER_EN
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter int PSEL_INDEX = 0
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Tirq
);

  timer_state_t state_q, state_d;
  logic [2:0]   ctrl_q, ctrl_d;
  logic [31:0]  load_q, load_d;
  logic [31:0]  count_q, count_d;
  logic         expired_q, expired_d;
  logic [31:0]  prdata_q, prdata_d;
  logic         presc_clr;
  logic         tick;
  logic         unused_bits;

  logic       sel, wr_en, rd_setup, ctrl_wr, ctrl_off;
  logic [5:0] word_addr;

  assign sel       = Pselx[PSEL_INDEX];
  assign wr_en     = sel & Penable & Pwrite;
  assign rd_setup  = sel & ~Penable & ~Pwrite;
  assign word_addr = Paddr[7:2];
  assign ctrl_wr   = wr_en && (word_addr == CTRL_OFF[7:2]);
  assign ctrl_off  = ctrl_wr && !Pwdata[CTRL_EN_BIT];

`ifdef TIMER_PRESCALER_EN
  logic [7:0] prescale_q, prescale_d;

  timer_prescaler u_prescaler (
    .clk    (Hclk),
    .resetn (Hresetn),
    .clr    (presc_clr),
    .div    (prescale_q),
    .tick   (tick)
  );

  // PRESCALE register
  always_comb begin
    prescale_d = prescale_q;
    if (wr_en && (word_addr == PRESCALE_OFF[7:2])) prescale_d = Pwdata[7:0];
  end

  // PRESCALE storage
  always_ff @(posedge Hclk) begin
    if (!Hresetn) prescale_q <= 8'd0;
    else          prescale_q <= prescale_d;
  end

  assign unused_bits = ^{Paddr[31:8], Paddr[1:0], Pselx};
`else
  assign tick        = 1'b1;
  assign unused_bits = ^{Paddr[31:8], Paddr[1:0], Pselx, presc_clr};
`endif

  // Register writes, counter FSM next state, and read-data capture in the setup phase
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    expired_d = expired_q;
    prdata_d  = prdata_q;
    presc_clr = 1'b0;

    if (ctrl_wr) ctrl_d = Pwdata[2:0];
    if (wr_en && (word_addr == LOAD_OFF[7:2])) load_d = Pwdata;
    if (wr_en && (word_addr == STATUS_OFF[7:2]) && Pwdata[0]) expired_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_wr && Pwdata[CTRL_EN_BIT] && !ctrl_q[CTRL_EN_BIT]) begin
          state_d   = RUN;
          count_d   = load_q;
          presc_clr = 1'b1;
        end
      end
      RUN: begin
        // Hardware set comes after the W1C above so a simultaneous set wins
        if (tick && (count_q == 32'd0)) expired_d = 1'b1;
        if (ctrl_off) begin
          state_d = IDLE;
        end else if (tick) begin
          if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
          end else if (ctrl_q[CTRL_AR_BIT]) begin
            count_d = load_q;
          end else begin
            ctrl_d[CTRL_EN_BIT] = 1'b0;
            state_d             = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_setup) begin
      case (word_addr)
        CTRL_OFF[7:2]:     prdata_d = {29'd0, ctrl_q};
        LOAD_OFF[7:2]:     prdata_d = load_q;
        COUNT_OFF[7:2]:    prdata_d = count_q;
        STATUS_OFF[7:2]:   prdata_d = {31'd0, expired_q};
`ifdef TIMER_PRESCALER_EN
        PRESCALE_OFF[7:2]: prdata_d = {24'd0, prescale_q};
`endif
        default:           prdata_d = 32'd0;
      endcase
    end
  end

  // Counter FSM state register
  always_ff @(posedge Hclk) begin
    if (!Hresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Register file and read-data register
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      ctrl_q    <= 3'd0;
      load_q    <= 32'd0;
      count_q   <= 32'd0;
      expired_q <= 1'b0;
      prdata_q  <= 32'd0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      prdata_q  <= prdata_d;
    end
  end

  assign Prdata = prdata_q;
  assign Tirq   = expired_q & ctrl_q[CTRL_IRQ_BIT];

endmodule

// File: tb/tb_apb_timer_slave.sv
// tb/tb_apb_timer_slave.sv - directed self-checking bench for apb_timer_slave
module tb_apb_timer_slave;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Tirq;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] SEL = 3'b001;

  apb_timer_slave #(.PSEL_INDEX(0)) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .Pselx   (Pselx),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Paddr   (Paddr),
    .Pwdata  (Pwdata),
    .Prdata  (Prdata),
    .Tirq    (Tirq)
  );

  always #5 Hclk = ~Hclk;

  // Transfers are entered 1 time unit after a rising edge and return at the same phase
  task automatic apb_write(input logic [2:0] sv, input logic [7:0] a, input logic [31:0] d);
    Pselx = sv; Penable = 1'b0; Pwrite = 1'b1; Paddr = {24'd0, a}; Pwdata = d;
    @(posedge Hclk); #1 Penable = 1'b1;
    @(posedge Hclk); #1 Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] sv, input logic [7:0] a, output logic [31:0] d);
    Pselx = sv; Penable = 1'b0; Pwrite = 1'b0; Paddr = {24'd0, a};
    @(posedge Hclk); #1 Penable = 1'b1; d = Prdata;
    @(posedge Hclk); #1 Pselx = 3'b000; Penable = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic [7:0]  offs [6];
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20};
    n_checks++;
    if (Prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h want 0", Prdata); end
    n_checks++;
    if (Tirq !== 1'b0) begin n_fail++; $display("FAIL reset_tirq: got %b want 0", Tirq); end
    for (int i = 0; i < 6; i++) begin
      apb_read(SEL, offs[i], rd);
      n_checks++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_read_%h: got %h want 0", offs[i], rd); end
    end
  endtask

  task automatic test_one_shot;
    logic [31:0] rd;
    apb_write(SEL, 8'h10, 32'h0);
    apb_write(SEL, 8'h04, 32'd5);
    apb_write(SEL, 8'h00, 32'h1);
    repeat (10) @(posedge Hclk);
    #1;
    apb_read(SEL, 8'h0C, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL oneshot_status: got %h want 1", rd); end
    apb_read(SEL, 8'h00, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL oneshot_ctrl: got %h want 0", rd); end
    apb_read(SEL, 8'h08, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL oneshot_count: got %h want 0", rd); end
    apb_write(SEL, 8'h0C, 32'h1);
    apb_read(SEL, 8'h0C, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL oneshot_w1c: got %h want 0", rd); end
  endtask

  task automatic test_irq_timing;
    logic [31:0] rd;
    int k;
    apb_write(SEL, 8'h00, 32'h5);
    k = 0;
    while (Tirq !== 1'b1 && k < 20) begin @(posedge Hclk); #1; k++; end
    n_checks++;
    if (k != 6) begin n_fail++; $display("FAIL irq_latency: got %0d cycles want 6", k); end
    apb_read(SEL, 8'h00, rd);
    n_checks++;
    if (rd !== 32'h4) begin n_fail++; $display("FAIL irq_ctrl_after: got %h want 4", rd); end
    apb_write(SEL, 8'h0C, 32'h1);
    n_checks++;
    if (Tirq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", Tirq); end
  endtask

  task automatic test_auto_reload;
    logic [31:0] rd;
    int k;
    apb_write(SEL, 8'h04, 32'd3);
    apb_write(SEL, 8'h00, 32'h7);
    k = 0;
    while (Tirq !== 1'b1 && k < 20) begin @(posedge Hclk); #1; k++; end
    n_checks++;
    if (k != 4) begin n_fail++; $display("FAIL ar_irq_latency: got %0d cycles want 4", k); end
    apb_read(SEL, 8'h08, rd);
    n_checks++;
    if (rd !== 32'd3) begin n_fail++; $display("FAIL ar_reload: got %h want 3", rd); end
    // This en=0 write commits on the very edge of the next expiry tick
    apb_write(SEL, 8'h00, 32'h6);
    apb_read(SEL, 8'h08, rd);
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL ar_stop_no_reload: got %h want 0", rd); end
    apb_read(SEL, 8'h0C, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL ar_stop_expired: got %h want 1", rd); end
    n_checks++;
    if (Tirq !== 1'b1) begin n_fail++; $display("FAIL ar_tirq_high: got %b want 1", Tirq); end
    apb_write(SEL, 8'h0C, 32'h1);
    n_checks++;
    if (Tirq !== 1'b0) begin n_fail++; $display("FAIL ar_tirq_fall: got %b want 0", Tirq); end
  endtask

  task automatic test_w1c_collision;
    logic [31:0] rd;
    apb_write(SEL, 8'h00, 32'h0);
    apb_write(SEL, 8'h04, 32'd1);
    apb_write(SEL, 8'h00, 32'h1);
    apb_write(SEL, 8'h0C, 32'h1);
    apb_read(SEL, 8'h0C, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL w1c_collision: got %h want 1", rd); end
  endtask

  task automatic test_prescale;
    logic [31:0] rd;
    logic [31:0] exp_ps, e0, e1, e2;
`ifdef TIMER_PRESCALER_EN
    exp_ps = 32'd3; e0 = 32'd2; e1 = 32'd2; e2 = 32'd1;
`else
    exp_ps = 32'd0; e0 = 32'd2; e1 = 32'd0; e2 = 32'd0;
`endif
    apb_write(SEL, 8'h10, 32'hFFFF_FF03);
    apb_read(SEL, 8'h10, rd);
    n_checks++;
    if (rd !== exp_ps) begin n_fail++; $display("FAIL ps_readback: got %h want %h", rd, exp_ps); end
    apb_write(SEL, 8'h04, 32'd2);
    apb_write(SEL, 8'h00, 32'h1);
    apb_read(SEL, 8'h08, rd);
    n_checks++;
    if (rd !== e0) begin n_fail++; $display("FAIL ps_count0: got %h want %h", rd, e0); end
    apb_read(SEL, 8'h08, rd);
    n_checks++;
    if (rd !== e1) begin n_fail++; $display("FAIL ps_count1: got %h want %h", rd, e1); end
    apb_read(SEL, 8'h08, rd);
    n_checks++;
    if (rd !== e2) begin n_fail++; $display("FAIL ps_count2: got %h want %h", rd, e2); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd;
    Pselx = SEL; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h4; Pwdata = 32'hDEAD_BEEF;
    @(posedge Hclk); #1 Penable = 1'b1; Hresetn = 1'b0;
    @(posedge Hclk); #1 Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
    @(posedge Hclk); #1 Hresetn = 1'b1;
    n_checks++;
    if (Prdata !== 32'h0) begin n_fail++; $display("FAIL abort_prdata: got %h want 0", Prdata); end
    apb_read(SEL, 8'h04, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL abort_load: got %h want 0", rd); end
    apb_read(SEL, 8'h00, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL abort_ctrl: got %h want 0", rd); end
  endtask

  task automatic test_psel;
    logic [31:0] rd;
    apb_write(SEL, 8'h04, 32'h55);
    apb_read(SEL, 8'h04, rd);
    n_checks++;
    if (rd !== 32'h55) begin n_fail++; $display("FAIL psel_load: got %h want 55", rd); end
    apb_write(3'b010, 8'h04, 32'h1234);
    apb_write(3'b100, 8'h04, 32'h5678);
    apb_read(3'b110, 8'h00, rd);
    n_checks++;
    if (rd !== 32'h55) begin n_fail++; $display("FAIL psel_hold: got %h want 55", rd); end
    apb_read(SEL, 8'h04, rd);
    n_checks++;
    if (rd !== 32'h55) begin n_fail++; $display("FAIL psel_nowrite: got %h want 55", rd); end
  endtask

  initial begin
    Hresetn = 1'b0; Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = 32'h0; Pwdata = 32'h0;
    repeat (3) @(posedge Hclk);
    #1 Hresetn = 1'b1;
    test_reset;
    test_one_shot;
    test_irq_timing;
    test_auto_reload;
    test_w1c_collision;
    test_prescale;
    test_reset_abort;
    test_psel;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_timer_slave.md
# apb_timer_slave

APB timer peripheral downstream of the AHB-to-APB bridge. It responds to one bit of the bridge's `Pselx` bus, decodes `Paddr`, and commits writes in the APB access phase. It returns `Prdata` to the bridge with zero wait states, because the bridge has no `Pready`. It implements a prescaled 32-bit down-counter with auto-reload, a sticky expiry flag and an interrupt output.

## Interface
- `PSEL_INDEX`, default 0: which bit of `Pselx` selects this slave (0..2).
- `Hclk` input, 1 bit: system clock, shared with the bridge.
- `Hresetn` input, 1 bit: reset, synchronous, active-low.
- `Pselx` input, 3 bits: bridge slave selects; only bit `PSEL_INDEX` is used.
- `Penable` input, 1 bit: APB access phase.
- `Pwrite` input, 1 bit: 1 = write, 0 = read.
- `Paddr` input, 32 bits: byte address; only `Paddr[7:0]` is decoded.
- `Pwdata` input, 32 bits: write data.
- `Prdata` output, 32 bits: read data to the bridge.
- `Tirq` output, 1 bit: level interrupt, equal to `expired & CTRL.irq_en`.

## Operation
Register map (offsets in `Paddr[7:0]`, word aligned; `Paddr[1:0]` ignored):
- 0x00 CTRL, RW. Bit0 `en`, bit1 `auto_reload`, bit2 `irq_en`. Other bits read 0.
- 0x04 LOAD, RW, 32 bits. Reload value.
- 0x08 COUNT, RO, 32 bits. Current counter value. Writes are ignored.
- 0x0C STATUS. Bit0 `expired`, sticky. Writing 1 to bit0 clears it; writing 0 has no effect.
- 0x10 PRESCALE, RW, 8 bits. A tick occurs every PRESCALE+1 cycles. Bits [31:8] read 0.
- Any other offset reads 0x0000_0000; writes to it are ignored.

APB behaviour:
- `sel = Pselx[PSEL_INDEX]`.
- Setup phase is `sel & !Penable`. Access phase is `sel & Penable`.
- Write commit: in an access phase with `Pwrite`=1, the register updates at that clock edge. It is visible on the next cycle.
- Read capture: in a setup phase with `Pwrite`=0, `Prdata` is registered from the addressed register. It is valid throughout the access phase.
- `Prdata` holds its last value at all other times.
- No error response; the bridge always returns OKAY.

Counter state machine (states IDLE, RUN):
- IDLE → RUN when CTRL is written with `en`=1 while `en` was 0. COUNT loads from LOAD and the prescaler clears.
- RUN: each tick, COUNT decrements by 1 when COUNT > 0.
- RUN, tick with COUNT == 0: `expired` is set.
  - If `auto_reload`=1: COUNT ← LOAD, stay in RUN.
  - If `auto_reload`=0: `en` clears, go to IDLE, COUNT stays 0.
- RUN → IDLE when CTRL is written with `en`=0. COUNT freezes at its current value.
- Writing LOAD during RUN does not change COUNT; the new value is used at the next reload.
- LOAD = 0 with `auto_reload`=1: `expired` sets on every tick.
- Arithmetic: COUNT is unsigned 32-bit and never wraps below 0. The prescale counter is 8 bits and resets to 0 on each tick.

Simultaneous events:
- W1C on STATUS in the same cycle as a hardware set: the set wins and `expired` stays 1.
- CTRL write to `en`=0 in the same cycle as an expiry tick: `expired` sets, COUNT does not reload, state goes to IDLE.

## Timing
- All outputs and state are reset synchronously on the edge where `Hresetn`=0.
- Reset values: `Prdata`=0, `Tirq`=0, CTRL=0, LOAD=0, COUNT=0, STATUS=0, PRESCALE=0, state IDLE.
- Reset in the middle of an APB transfer or a count aborts it. Nothing is committed on that edge.
- Write to read-back latency: a read whose setup phase starts the cycle after the access phase returns the new value.
- Enable to first decrement: PRESCALE+1 cycles after the CTRL write edge.
- `Tirq` asserts one cycle after the tick that sets `expired`, since `expired` is registered.

## Configuration
- `TIMER_PRESCALER_EN` defined: the PRESCALE register and the prescaler exist as described.
- `TIMER_PRESCALER_EN` undefined:
  - A tick occurs every cycle.
  - Offset 0x10 reads 0 and ignores writes, like an unmapped offset.
  - No prescaler logic is instantiated.

## Structure
- Package `apb_timer_pkg` holds:
  - register offset constants (`CTRL_OFF` … `PRESCALE_OFF`);
  - CTRL bit-position constants;
  - the `timer_state_t` enum (IDLE, RUN).
- Sub-module `timer_prescaler` takes inputs clk, reset, `clr`, 8-bit `div` and outputs the 1-cycle `tick` pulse. It is only instantiated under `TIMER_PRESCALER_EN`.

## Test plan
- Reset, then read all offsets 0x00–0x10 and 0x20: every read returns 0x0. `Tirq`=0.
- Write LOAD=5, PRESCALE=0, CTRL=0x1 (one-shot): `expired` sets 6 cycles after enable. CTRL reads 0x0. COUNT reads 0.
- LOAD=3, CTRL=0x7 (`auto_reload`, `irq_en`): `Tirq` rises, COUNT reads back 3 after expiry. Write STATUS=1: `Tirq` falls the next cycle.
- PRESCALE=3, LOAD=2, CTRL=0x1: COUNT decrements every 4 cycles. With the macro undefined, it decrements every cycle.
- W1C on STATUS issued in the same cycle as an expiry tick: STATUS reads 0x1.
- Assert `Hresetn`=0 during a write access phase to LOAD=0xDEAD_BEEF: LOAD reads 0x0 after reset. `Pselx` bits other than `PSEL_INDEX` never trigger reads or writes.
